// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - valid/ready stream bundle carried out of fifo_rd_stream
interface fifo_rd_stream_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read stage: absorbs 1-cycle read latency, skid-buffers into a stream
// Optional build macro FIFO_RD_STREAM_STATS_EN adds saturating beat_cnt/stall_cnt outputs.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  fifo_rd_stream_if.master      m,
  output logic                  busy,
  output logic                  err_underflow
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           stall_cnt
`endif
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [FIFO_WIDTH-1:0] buffer [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [OCC_W-1:0]      occ;
  logic                  inflight;
  logic [OCC_W:0]        level;
  logic                  capture;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue only when buffered plus in-flight beats leave a guaranteed free slot,
  // so the read side never depends on m_ready.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    m.m_valid  = 1'b0;
    m.m_data   = buffer[head];
    capture    = 1'b0;
    pop        = 1'b0;
    level      = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};

    if (flush) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    if (en)  state_nxt = RUN;
        RUN:     if (!en) state_nxt = IDLE;
        FLUSH:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    fifo_rd_en = !rst && !flush && (state == RUN) && !fifo_empty &&
                 (level < (OCC_W + 1)'(BUF_DEPTH));
    m.m_valid  = (occ != '0) && (state != FLUSH) && !flush;
    capture    = inflight && (state != FLUSH) && !flush;
    pop        = m.m_valid && m.m_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      occ           <= '0;
      inflight      <= 1'b0;
      head          <= '0;
      tail          <= '0;
      err_underflow <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buffer[i] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (fifo_underflow) err_underflow <= 1'b1;
      if (flush) begin
        occ  <= '0;
        head <= tail;
      end else begin
        if (capture) begin
          buffer[tail] <= fifo_data_out;
          tail         <= ptr_inc(tail);
        end
        if (pop) head <= ptr_inc(head);
        case ({capture, pop})
          2'b10:   occ <= occ + OCC_W'(1);
          2'b01:   occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

  assign busy = (occ != '0) || inflight || (state != IDLE);

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (beat_cnt != '1)) beat_cnt <= beat_cnt + 32'd1;
      if (m.m_valid && !m.m_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench: FIFO model + word-order scoreboard, directed and random
module tb_fifo_rd_stream;
  localparam int W     = 16;
  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         flush;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_data_out;
  logic         fifo_empty;
  logic         fifo_underflow;
  logic         busy;
  logic         err_underflow;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]  beat_cnt;
  logic [31:0]  stall_cnt;
`endif

  fifo_rd_stream_if #(.WIDTH(W)) s ();

  fifo_rd_stream #(.FIFO_WIDTH(W), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .m(s), .busy(busy), .err_underflow(err_underflow)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_pass = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] sb[$];
  int           cyc, beats, stalls, reads;
  logic [W-1:0] last_beat;
  logic         stall_prev;
  logic [W-1:0] held_data;
  logic         rd_log[64];
  logic         v_log[64];
  logic         b_log[64];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic load(input int n, input logic [W-1:0] base);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(base + W'(i));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; flush = 1'b0; s.m_ready = 1'b1; fifo_underflow = 1'b0;
    fifo_empty = (fq.size() == 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rd_en_in_reset", fifo_rd_en, 0);
    end
    @(negedge clk);
    chk("reset_valid", s.m_valid, 0);
    chk("reset_data", s.m_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err_underflow, 0);
    rst = 1'b0; en = 1'b0;
    sb.delete();
    stall_prev = 1'b0; cyc = 0; beats = 0; stalls = 0; reads = 0;
  endtask

  // One cycle: drive at negedge, observe #1 later, advance the FIFO model on the edge.
  task automatic step(input logic en_i, input logic flush_i, input logic ready_i);
    logic         rd_now;
    logic [W-1:0] w;
    logic [W-1:0] want;
    en = en_i; flush = flush_i; s.m_ready = ready_i;
    fifo_empty = (fq.size() == 0);
    #1;
    rd_now = fifo_rd_en;
    w = '0;
    if (cyc < 64) begin
      rd_log[cyc] = rd_now; v_log[cyc] = s.m_valid; b_log[cyc] = busy;
    end
    if (flush_i) chk("valid_low_in_flush", s.m_valid, 0);
    else if (stall_prev) begin
      chk("hold_valid", s.m_valid, 1);
      chk("hold_data", s.m_data, held_data);
    end
    if (s.m_valid && ready_i) begin
      chk("beat_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        want = sb.pop_front();
        chk("beat_data", s.m_data, want);
      end
      beats++;
      last_beat = s.m_data;
    end
    if (s.m_valid && !ready_i) stalls++;
    stall_prev = s.m_valid && !ready_i;
    held_data  = s.m_data;
    if (flush_i) sb.delete();
    if (rd_now) begin
      chk("rd_only_when_nonempty", fifo_empty, 0);
      reads++;
      if (fq.size() != 0) begin
        w = fq.pop_front();
        sb.push_back(w);
      end
    end
    chk("occ_bound", (sb.size() <= DEPTH), 1);
    @(posedge clk); #1;
    fifo_data_out = rd_now ? w : W'($urandom);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int           n;
    logic         got;
    logic [W-1:0] first;
    rst = 1'b1; en = 1'b0; flush = 1'b0; s.m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_underflow = 1'b0; fifo_data_out = '0;
    @(negedge clk);

    // Reset with FIFO holding words
    load(4, 16'h0001);
    do_reset();

    // Full-rate stream
    load(8, 16'h0001);
    do_reset();
    for (int c = 0; c < 13; c++) step(c < 9, 1'b0, 1'b1);
    for (int c = 0; c < 13; c++) begin
      chk("s2_rd_timing", rd_log[c], (c >= 1 && c <= 8));
      chk("s2_valid_timing", v_log[c], (c >= 3 && c <= 10));
    end
    chk("s2_beats", beats, 8);
    chk("s2_idle", b_log[12], 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("s2_beat_cnt", beat_cnt, 8);
    chk("s2_stall_cnt", stall_cnt, 0);
`endif

    // Backpressure
    load(8, 16'h0001);
    do_reset();
    for (int c = 0; c < 30; c++) step(c < 20, 1'b0, !(c >= 3 && c <= 9));
    n = 0;
    for (int c = 0; c < 10; c++) n += int'(rd_log[c]);
    chk("s3_reads_under_stall", n, 3);
    chk("s3_valid_held", v_log[9], 1);
    chk("s3_beats", beats, 8);
    chk("s3_drained", sb.size() + fq.size(), 0);

    // Single word
    load(1, 16'hBEEF);
    do_reset();
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 1'b1);
    chk("s4_reads", reads, 1);
    chk("s4_beats", beats, 1);
    chk("s4_data", last_beat, 16'hBEEF);

    // Flush with a beat in flight
    load(8, 16'h0001);
    do_reset();
    for (int c = 0; c < 5; c++) step(1'b1, c == 4, 1'b0);
    chk("s5_rd_before_flush", rd_log[3], 1);
    chk("s5_valid_in_flush", v_log[4], 0);
    got = 1'b0; first = '0;
    for (int c = 5; c < 30; c++) begin
      step(1'b1, 1'b0, 1'b1);
      if (!got && beats == 1) begin got = 1'b1; first = last_beat; end
    end
    chk("s5_beat_seen", got, 1);
    chk("s5_first_after_flush", first, 16'h0004);
    chk("s5_idle_after_flush", b_log[6], 0);
    chk("s5_beats", beats, 5);

    // Sticky underflow error
    load(0, 16'h0000);
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    fifo_underflow = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    fifo_underflow = 1'b0;
    chk("s6_err_set", err_underflow, 1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("s6_err_after_flush", err_underflow, 1);
    do_reset();

    // Random traffic
    fq.delete();
    for (int i = 0; i < 6; i++) fq.push_back(W'($urandom));
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (fq.size() < 6 && $urandom_range(0, 3) == 0) fq.push_back(W'($urandom));
      step($urandom_range(0, 7) != 0, $urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 200 && (fq.size() != 0 || sb.size() != 0); k++) step(1'b1, 1'b0, 1'b1);
    chk("rand_drained", sb.size() + fq.size(), 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("rand_beat_cnt", beat_cnt, beats);
    chk("rand_stall_cnt", stall_cnt, stalls);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer stage placed directly downstream of the FIFO.
- Drives the FIFO read enable and absorbs the FIFO's 1-cycle registered read latency.
- Presents the read data as a valid/ready stream, with a small skid buffer so throughput stays at 1 beat/cycle.
- Also provides flush and enable control, and a sticky error flag if the FIFO reports underflow.

Parameters:
- FIFO_WIDTH, 16, data width; must match the FIFO's data width.
- BUF_DEPTH, 3, skid buffer entries; minimum 3; no other constraint required.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  level; 1 = fetch from FIFO
- flush  input  1  discard buffered and in-flight data
- fifo_rd_en  output  1  to FIFO rd_en
- fifo_data_out  input  FIFO_WIDTH  from FIFO data_out; valid the cycle after an accepted rd_en
- fifo_empty  input  1  from FIFO empty
- fifo_underflow  input  1  from FIFO underflow
- m_data  output  FIFO_WIDTH  stream data
- m_valid  output  1  stream valid
- m_ready  input  1  stream ready from consumer
- busy  output  1  1 when occ != 0, inflight = 1, or state != IDLE
- err_underflow  output  1  sticky; set on fifo_underflow

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, occ=0, inflight=0, head/tail=0, buffer=0.
  - m_valid=0, m_data=0, err_underflow=0, busy=0.
  - fifo_rd_en is held 0 combinationally while rst=1.
- FSM states:
  - IDLE -> RUN when en=1 and flush=0.
  - RUN -> IDLE when en=0. Issuing stops; buffered data and any in-flight beat are still delivered.
  - Any state -> FLUSH when flush=1 (flush has priority over en).
  - FLUSH -> IDLE on the first cycle with flush=0.
- Issue rule: fifo_rd_en = (state==RUN) && !fifo_empty && (occ + inflight < BUF_DEPTH - 1 + 1).
  - That is, a read is issued only when a free slot is guaranteed.
  - No combinational path from m_ready to fifo_rd_en.
- In-flight tracking: inflight <= fifo_rd_en each cycle.
- Capture: when inflight=1 and state!=FLUSH, fifo_data_out is written to buffer[tail], tail advances and wraps at BUF_DEPTH-1 -> 0, and occ increments.
- Latency: fifo_rd_en high in cycle N -> data captured at the end of N+1 -> m_valid=1 in N+2.
- Stream output:
  - m_valid = (occ != 0) && state != FLUSH.
  - m_data = buffer[head].
  - A pop occurs on m_valid && m_ready: head advances (same wrap rule) and occ decrements.
  - Simultaneous capture and pop leaves occ unchanged.
  - m_data and m_valid are stable while m_valid=1 and m_ready=0.
  - m_data is don't-care when m_valid=0.
- Ordering: stream order equals FIFO read order; no loss or duplication except on flush.
- Flush:
  - In the flush cycle: occ<=0, head<=tail, fifo_rd_en=0.
  - A beat arriving while in FLUSH (inflight=1) is discarded.
  - A handshake cannot occur in FLUSH because m_valid is forced 0.
- Underflow:
  - fifo_underflow=1 sets err_underflow. It should never fire, since issue is gated by !fifo_empty.
  - err_underflow clears only on rst. Flush does not clear it.
- Full throughput: with m_ready=1 and the FIFO non-empty, steady state is occ<=1, inflight=1, and one beat per cycle.
- occ width: $clog2(BUF_DEPTH+1); never exceeds BUF_DEPTH (verification asserts this).
- Reset mid-operation: all state is cleared at the edge. The FIFO's own read pointer has already advanced for any in-flight read; the system resets both together.

Optional Feature:
- Macro: FIFO_RD_STREAM_STATS_EN.
- When defined, adds two outputs:
  - beat_cnt (32): increments on each m_valid&&m_ready.
  - stall_cnt (32): increments on each cycle with m_valid&&!m_ready.
  - Both counters saturate at all-ones and clear on rst only.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, FIFO holds 4 words -> fifo_rd_en=0, m_valid=0, m_data=0, busy=0, err_underflow=0.
- Stream with ready high: FIFO preloaded with 0x0001..0x0008, en=1 at cycle 0, m_ready=1 -> fifo_rd_en high cycles 1-8, m_valid high cycles 3-10 carrying 0x0001..0x0008 in order, then busy=0.
- Backpressure: as above with m_ready=0 cycles 3-9 -> fifo_rd_en stops after 3 reads, m_data holds 0x0001 stable, occ=3; release m_ready -> all 8 words delivered in order, none lost.
- Empty boundary: FIFO holds 1 word 0xBEEF, en=1 -> exactly one fifo_rd_en pulse, one beat 0xBEEF, fifo_underflow never asserted.
- Flush with in-flight: m_ready=0, occ=2, fifo_rd_en=1 in cycle N, flush=1 in cycle N+1 -> m_valid=0 from N+1, beat arriving in N+1 discarded, occ=0; after flush drops and en=1, next beat is the next FIFO word.
- Forced underflow: drive fifo_underflow=1 for 1 cycle -> err_underflow=1, stays set through flush, clears only on rst; with FIFO_RD_STREAM_STATS_EN, beat_cnt equals the number of delivered beats (8 in scenario 2).
